// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared definitions for the clock-domain-crossing receiver blocks.
//   sync_state_t   : receiver FSM states (IDLE waiting for an enable edge,
//                    CAPTURED holding a word while the enable stays high)
//   NUM_STAGES_MIN : shallowest legal enable synchronizer
//   NUM_STAGES_MAX : deepest legal enable synchronizer
//   stages_legal() : true when a requested synchronizer depth is in range
// No ports (package).
// -----------------------------------------------------------------------------
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CAPTURED = 1'b1
  } sync_state_t;

  localparam int NUM_STAGES_MIN = 2;
  localparam int NUM_STAGES_MAX = 4;

  function automatic bit stages_legal(input int n);
    return (n >= NUM_STAGES_MIN) && (n <= NUM_STAGES_MAX);
  endfunction

endpackage

// File: rtl/data_sync_if.sv
// -----------------------------------------------------------------------------
// data_sync_if
// Groups the crossed bus, its enable and the destination-domain results.
//   unsync_bus   : word from the source domain (stable while bus_enable high)
//   bus_enable   : source-domain level enable, high = new word present
//   sync_bus     : last captured word
//   enable_pulse : one-cycle strobe when sync_bus first shows a new word
//   xfer_cnt     : wrapping count of completed captures
//   busy         : receiver is holding a captured word
// Modports:
//   master : source side / consumer (drives bus and enable, reads results)
//   slave  : the receiver (reads bus and enable, drives results)
// -----------------------------------------------------------------------------
interface data_sync_if #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 8
);

  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic [BUS_WIDTH-1:0] sync_bus;
  logic                 enable_pulse;
  logic [CNT_WIDTH-1:0] xfer_cnt;
  logic                 busy;

  modport master (
    output unsync_bus,
    output bus_enable,
    input  sync_bus,
    input  enable_pulse,
    input  xfer_cnt,
    input  busy
  );

  modport slave (
    input  unsync_bus,
    input  bus_enable,
    output sync_bus,
    output enable_pulse,
    output xfer_cnt,
    output busy
  );

endinterface

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Single-bit synchronizer: NUM_STAGES flops in series. Only ever use it for a
// signal that may be sampled a cycle early or late without harm (levels,
// slow enables); multi-bit values must not be passed through it bit by bit.
// Ports:
//   clk  : destination clock
//   rst  : synchronous active-high reset, clears every stage
//   din  : asynchronous single-bit input (sampled by stage 0)
//   dout : synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_chain
  import cdc_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  // Depth is checked here as well so the chain is safe to reuse on its own.
  if (!stages_legal(NUM_STAGES)) begin : g_bad_depth
    $fatal(1, "sync_chain: NUM_STAGES=%0d outside %0d..%0d",
           NUM_STAGES, NUM_STAGES_MIN, NUM_STAGES_MAX);
  end

  logic [NUM_STAGES-1:0] stages;

  // Shift towards the MSB; stage 0 is the only flop that sees the raw input.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[NUM_STAGES-2:0], din};
    end
  end

  assign dout = stages[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// -----------------------------------------------------------------------------
// data_sync
// Destination-domain receiver for a multi-bit bus launched from a foreign
// clock. Only the enable is synchronized; the bus is captured directly once
// the synchronized enable rises, by which time the source guarantees the bus
// has been stable for several destination cycles.
// Parameters:
//   BUS_WIDTH  : width of the crossed data bus
//   NUM_STAGES : enable synchronizer depth (2..4)
//   CNT_WIDTH  : width of the wrapping transfer counter
// Ports:
//   CLK : destination clock
//   RST : synchronous active-high reset
//   io  : data_sync_if slave modport (bus, enable, sync_bus, enable_pulse,
//         xfer_cnt, busy)
// -----------------------------------------------------------------------------
module data_sync
  import cdc_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic         CLK,
  input  logic         RST,
  data_sync_if.slave   io
);

  if (!stages_legal(NUM_STAGES) || (BUS_WIDTH < 1)) begin : g_bad_cfg
    $fatal(1, "data_sync: illegal NUM_STAGES=%0d or BUS_WIDTH=%0d",
           NUM_STAGES, BUS_WIDTH);
  end

  logic                 en_sync;
  logic                 capture;
  sync_state_t          state_q;
  sync_state_t          state_d;
  logic [BUS_WIDTH-1:0] sync_bus_q;
  logic                 pulse_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_en_chain (
    .clk  (CLK),
    .rst  (RST),
    .din  (io.bus_enable),
    .dout (en_sync)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // CAPTURED is only left once the synchronized enable drops, which is what
  // turns a long enable level into exactly one capture.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_sync) begin
          state_d = CAPTURED;
          capture = 1'b1;
        end
      end
      CAPTURED: begin
        if (!en_sync) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The bus is sampled straight from the foreign domain: safe because the
  // enable took NUM_STAGES cycles to arrive and the source holds the bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_bus_q <= '0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pulse_q <= capture;
      if (capture) begin
        sync_bus_q <= io.unsync_bus;
        cnt_q      <= cnt_q + 1'b1;
      end
    end
  end

  assign io.sync_bus     = sync_bus_q;
  assign io.enable_pulse = pulse_q;
  assign io.xfer_cnt     = cnt_q;
  assign io.busy         = (state_q == CAPTURED);

endmodule

// File: tb/tb_data_sync.sv
// -----------------------------------------------------------------------------
// tb_data_sync
// Drives one shared stimulus stream into four receivers of different depth
// and counter width; each receiver has its own expected-capture queue and its
// own monitor.
// -----------------------------------------------------------------------------
module tb_data_sync;

  localparam int NUM_DUT = 4;
  localparam int MAX_CYC = 4096;

  typedef struct {
    int         edge_no;
    logic [7:0] word;
    int         cnt;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       drive_en = 1'b0;
  logic [7:0] drive_bus = 8'h00;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  bit   lvl_hist [MAX_CYC];
  bit   rst_hist [MAX_CYC];
  int   last_rst_edge;
  exp_t exp_q [NUM_DUT][$];
  int   model_cnt [NUM_DUT];
  logic [7:0] last_word [NUM_DUT];
  int   ns_of [NUM_DUT];
  int   cnt_mod [NUM_DUT];

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  data_sync_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) if0 ();
  data_sync_if #(.BUS_WIDTH(8), .CNT_WIDTH(2)) if1 ();
  data_sync_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) if2 ();
  data_sync_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) if3 ();

  assign if0.unsync_bus = drive_bus;
  assign if0.bus_enable = drive_en;
  assign if1.unsync_bus = drive_bus;
  assign if1.bus_enable = drive_en;
  assign if2.unsync_bus = drive_bus;
  assign if2.bus_enable = drive_en;
  assign if3.unsync_bus = drive_bus;
  assign if3.bus_enable = drive_en;

  data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .CNT_WIDTH(8)) dut0 (
    .CLK (CLK), .RST (RST), .io (if0.slave));
  data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .CNT_WIDTH(2)) dut1 (
    .CLK (CLK), .RST (RST), .io (if1.slave));
  data_sync #(.BUS_WIDTH(8), .NUM_STAGES(3), .CNT_WIDTH(8)) dut2 (
    .CLK (CLK), .RST (RST), .io (if2.slave));
  data_sync #(.BUS_WIDTH(8), .NUM_STAGES(4), .CNT_WIDTH(8)) dut3 (
    .CLK (CLK), .RST (RST), .io (if3.slave));

  // One destination cycle of stimulus. Reference rule: a rising enable level
  // first sampled at edge k yields one capture of the word at edge k+depth,
  // and a reset edge discards every capture not yet delivered.
  task automatic apply_stimulus(input bit rst_v, input bit en_v, input logic [7:0] word_v);
    int k;
    bit prev_en;
    @(negedge CLK);
    k = cyc + 1;
    if (k >= MAX_CYC) begin
      errors++;
      $display("[TB] FAIL cycle_budget: edge %0d, limit %0d", k, MAX_CYC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    RST       = rst_v;
    drive_en  = en_v;
    drive_bus = word_v;
    rst_hist[k] = rst_v;
    lvl_hist[k] = en_v;
    prev_en = (k - 1 > last_rst_edge) && lvl_hist[k-1];
    for (int d = 0; d < NUM_DUT; d++) begin
      if (rst_v) begin
        while (exp_q[d].size() > 0 && exp_q[d][exp_q[d].size()-1].edge_no >= k)
          void'(exp_q[d].pop_back());
        model_cnt[d] = 0;
      end else if (en_v && !prev_en) begin
        exp_t e;
        model_cnt[d] = (model_cnt[d] + 1) % cnt_mod[d];
        e.edge_no = k + ns_of[d];
        e.word    = word_v;
        e.cnt     = model_cnt[d];
        exp_q[d].push_back(e);
      end
    end
    if (rst_v) last_rst_edge = k;
  endtask

  task automatic transfer(input logic [7:0] w, input int hi, input int lo);
    repeat (hi) apply_stimulus(1'b0, 1'b1, w);
    repeat (lo) apply_stimulus(1'b0, 1'b0, w);
  endtask

  task automatic check_output(input int d, input logic pulse, input logic [7:0] word,
                              input int cnt, input logic busy);
    int   m;
    int   ns;
    bit   busy_exp;
    exp_t e;
    m  = cyc;
    ns = ns_of[d];
    while (exp_q[d].size() > 0 && exp_q[d][0].edge_no < m) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d missed_pulse: no pulse observed, required at edge %0d (now %0d)",
               d, exp_q[d][0].edge_no, m);
      void'(exp_q[d].pop_front());
    end
    if (rst_hist[m]) begin
      checks++;
      if (pulse !== 1'b0 || word !== 8'h00 || cnt != 0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL dut%0d reset_state: got pulse=%b bus=%h cnt=%0d busy=%b, required 0/00/0/0 at edge %0d",
                 d, pulse, word, cnt, busy, m);
      end
      last_word[d] = 8'h00;
    end else begin
      if (pulse === 1'b1) begin
        checks++;
        if (exp_q[d].size() == 0 || exp_q[d][0].edge_no != m) begin
          errors++;
          $display("[TB] FAIL dut%0d unexpected_pulse: pulse=1 at edge %0d, required next pulse at edge %0d",
                   d, m, (exp_q[d].size() > 0) ? exp_q[d][0].edge_no : -1);
        end else begin
          e = exp_q[d].pop_front();
          if (word !== e.word) begin
            errors++;
            $display("[TB] FAIL dut%0d capture_word: got %h, required %h at edge %0d", d, word, e.word, m);
          end
          checks++;
          if (cnt != e.cnt) begin
            errors++;
            $display("[TB] FAIL dut%0d xfer_cnt: got %0d, required %0d at edge %0d", d, cnt, e.cnt, m);
          end
          last_word[d] = e.word;
        end
      end else begin
        checks++;
        if (pulse !== 1'b0) begin
          errors++;
          $display("[TB] FAIL dut%0d pulse_level: got %b, required 0 at edge %0d", d, pulse, m);
        end
        checks++;
        if (word !== last_word[d]) begin
          errors++;
          $display("[TB] FAIL dut%0d hold_word: got %h, required %h at edge %0d", d, word, last_word[d], m);
        end
      end
      // Busy mirrors the enable level as sampled depth edges earlier, unless
      // a reset in that window flushed it.
      busy_exp = 1'b0;
      if (m - ns >= 1) begin
        busy_exp = lvl_hist[m-ns];
        for (int j = m - ns; j <= m; j++)
          if (rst_hist[j]) busy_exp = 1'b0;
      end
      checks++;
      if (busy !== busy_exp) begin
        errors++;
        $display("[TB] FAIL dut%0d busy: got %b, required %b at edge %0d", d, busy, busy_exp, m);
      end
    end
  endtask

  always @(negedge CLK) if (cyc > 0) check_output(0, if0.enable_pulse, if0.sync_bus, int'(if0.xfer_cnt), if0.busy);
  always @(negedge CLK) if (cyc > 0) check_output(1, if1.enable_pulse, if1.sync_bus, int'(if1.xfer_cnt), if1.busy);
  always @(negedge CLK) if (cyc > 0) check_output(2, if2.enable_pulse, if2.sync_bus, int'(if2.xfer_cnt), if2.busy);
  always @(negedge CLK) if (cyc > 0) check_output(3, if3.enable_pulse, if3.sync_bus, int'(if3.xfer_cnt), if3.busy);

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ns_of   = '{2, 2, 3, 4};
    cnt_mod = '{256, 4, 256, 256};
    for (int d = 0; d < NUM_DUT; d++) begin
      model_cnt[d] = 0;
      last_word[d] = 8'h00;
    end
    rst_hist[1]   = 1'b1;
    lvl_hist[1]   = 1'b0;
    last_rst_edge = 1;

    $display("[TB] reset");
    repeat (2) apply_stimulus(1'b1, 1'b0, 8'h00);

    $display("[TB] basic capture");
    transfer(8'hA5, 6, 8);

    $display("[TB] hold without recapture");
    repeat (10) apply_stimulus(1'b0, 1'b1, 8'h11);
    repeat (10) apply_stimulus(1'b0, 1'b1, 8'h22);
    repeat (8)  apply_stimulus(1'b0, 1'b0, 8'h22);

    $display("[TB] back-to-back transfers");
    transfer(8'h01, 3, 3);
    transfer(8'h02, 3, 3);
    transfer(8'h03, 3, 8);

    $display("[TB] reset mid-operation");
    apply_stimulus(1'b0, 1'b1, 8'h5A);
    apply_stimulus(1'b1, 1'b1, 8'h5A);
    transfer(8'h5A, 8, 8);

    $display("[TB] counter wrap");
    repeat (2) apply_stimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) transfer(8'(8'h40 + i), 5, 5);

    $display("[TB] depth check word");
    transfer(8'h3C, 6, 8);

    $display("[TB] random transfers");
    for (int i = 0; i < 30; i++) begin
      transfer(8'($urandom_range(0, 255)), $urandom_range(5, 9), $urandom_range(1, 8));
    end

    repeat (12) apply_stimulus(1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    for (int d = 0; d < NUM_DUT; d++) begin
      checks++;
      if (exp_q[d].size() != 0) begin
        errors++;
        $display("[TB] FAIL dut%0d drain: %0d captures outstanding, required 0", d, exp_q[d].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sync.md
# data_sync

Multi-bit clock-domain-crossing receiver for the destination clock domain. It takes a data bus and a level enable, both launched from a foreign clock domain. It synchronizes only the enable through a flop chain, detects its rising edge, and captures the bus once it is stable. It then presents the captured word with a single-cycle valid pulse to destination-domain consumers such as the register file and ALU control.

## Interface
- BUS_WIDTH, 8, width of the crossed data bus
- NUM_STAGES, 2, synchronizer depth for the enable; legal range 2..4
- CNT_WIDTH, 8, width of the transfer counter
- CLK  in  1  destination-domain clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- unsync_bus  in  BUS_WIDTH  data from the source domain; must be stable while bus_enable is high
- bus_enable  in  1  source-domain level enable; high means unsync_bus holds a new word
- sync_bus  out  BUS_WIDTH  last captured word, registered
- enable_pulse  out  1  one-CLK pulse, high in the cycle sync_bus first shows a new word
- xfer_cnt  out  CNT_WIDTH  count of completed captures, wraps
- busy  out  1  high while the synchronized enable is high (state CAPTURED)

## Operation
- Enable chain: NUM_STAGES flops in series. Stage 0 samples bus_enable. en_sync is the last stage. The bus itself is never passed through the chain.
- FSM has two states, IDLE and CAPTURED, and resets to IDLE.
  - IDLE, en_sync=1: go to CAPTURED. Load sync_bus <= unsync_bus, set enable_pulse <= 1 and xfer_cnt <= xfer_cnt+1.
  - IDLE, en_sync=0: stay in IDLE. enable_pulse <= 0.
  - CAPTURED, en_sync=0: go to IDLE.
  - CAPTURED, en_sync=1: stay in CAPTURED. No recapture and no pulse.
- enable_pulse is high for exactly one cycle per en_sync rising edge. This holds however long bus_enable stays high.
- sync_bus holds its value between captures.
- xfer_cnt wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- busy = (state == CAPTURED), decoded from a flop.
- Source-side protocol contract: bus_enable stays high for at least NUM_STAGES+1 CLK periods, then low for at least NUM_STAGES+1 CLK periods. A shorter high may be missed. A shorter low may merge two transfers into one. This is documented behaviour, not an error.
- Reset with RST high at an edge:
  - chain, state, sync_bus, enable_pulse, xfer_cnt and busy all go to 0 / IDLE;
  - an in-flight capture is discarded.
- Reset release with bus_enable already high: the chain fills and a normal capture and pulse occur. This is intended.

## Timing
- Reset values: sync_bus=0, enable_pulse=0, xfer_cnt=0, busy=0.
- Latency:
  - bus_enable is first sampled high at edge E0.
  - en_sync goes high after edge E0+NUM_STAGES-1.
  - sync_bus, enable_pulse=1 and xfer_cnt update at edge E0+NUM_STAGES. For NUM_STAGES=2 that is 2 edges after first sample.
- enable_pulse falls at the next edge.
- busy rises with enable_pulse. It falls one edge after en_sync is sampled low.
- Throughput: at most one word per 2·(NUM_STAGES+1) CLK periods.
- RST takes priority over every other event in the same cycle.

## Structure
- Shared package cdc_pkg holds:
  - the state enum (IDLE, CAPTURED);
  - localparam bounds for NUM_STAGES (MIN=2, MAX=4).
- One sub-module, sync_chain: a parameterized NUM_STAGES-deep, 1-bit flop chain with synchronous active-high reset.
  - data_sync instantiates it for bus_enable.
  - It is reusable for other single-bit crossings.
- Elaboration check: fatal if NUM_STAGES is outside 2..4 or BUS_WIDTH < 1.

## Test plan
- Basic capture (defaults): unsync_bus=8'hA5, bus_enable high for 6 cycles, then low. Required response:
  - sync_bus=8'hA5 and enable_pulse=1 exactly 2 edges after first sample;
  - pulse width 1 cycle;
  - xfer_cnt=1;
  - busy high until en_sync drops.
- Hold without recapture: bus_enable high 20 cycles while unsync_bus changes 8'h11→8'h22 at cycle 10 (contract violation, tolerated). Required: sync_bus stays 8'h11, one pulse only, xfer_cnt=1.
- Back-to-back legal transfers: words 8'h01, 8'h02, 8'h03, each with 3 high / 3 low cycles. Required: three pulses, sync_bus sequence 01→02→03, xfer_cnt=3.
- Reset mid-operation: assert RST for 1 cycle while the chain holds 1 but before capture. Required:
  - all outputs 0 on the next edge, no pulse;
  - bus_enable still high, so after release a capture occurs NUM_STAGES edges later.
- Counter wrap (CNT_WIDTH=2): 5 transfers. Required: xfer_cnt sequence 1,2,3,0,1, and enable_pulse count = 5.
- Depth sweep (NUM_STAGES=3 and 4): single transfer of 8'h3C. Required: pulse exactly NUM_STAGES edges after first sample, sync_bus=8'h3C.
